pts_frame_serializer: RTL

- Downstream neighbour of the serial-to-parallel input stage.
- Captures one complete 48-sample x 16-bit parallel frame when the upstream stage signals it is full.
- Replays the frame one sample per accepted beat on a valid/ready stream toward the FFT core, and marks the final sample.
- Flags frames that arrive while it is still busy.

---
 rtl/pts_pkg.sv | 21 ++
 rtl/pts_frame_serializer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pts_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pts_pkg                                                         |
// | Purpose  : Shared types and default sizes for the parallel-to-serial      |
// |            frame serializer.                                               |
// | Contents : pts_state_t FSM encoding, default frame geometry, sample_t.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package pts_pkg;

  // Default frame geometry.
  localparam int PTS_NUM_SAMPLES = 48;
  localparam int PTS_SAMPLE_W    = 16;
  localparam int PTS_PAD_SAMPLES = 64;

  typedef enum logic {IDLE, SEND} pts_state_t;

  typedef logic [PTS_SAMPLE_W-1:0] sample_t;

endpackage : pts_pkg
`default_nettype wire

// File: rtl/pts_frame_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pts_frame_serializer                                            |
// | Purpose  : Captures one parallel frame of NUM_SAMPLES samples and replays  |
// |            it one sample per accepted beat on a valid/ready stream,       |
// |            flagging the final beat. Frames arriving while busy are        |
// |            dropped and raise a sticky overrun flag.                        |
// | Macro    : PTS_ZERO_PAD_EN - when defined, each frame is extended with     |
// |            zero beats up to PAD_SAMPLES total beats.                       |
// | Ports    : clk, n_rst (async, active-low)                                  |
// |            frame_valid, data_par[NUM_SAMPLES][SAMPLE_W] -> frame_ready    |
// |            serial_out, out_valid, out_last <- out_ready                    |
// |            overrun (sticky) <- clr_overrun                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pts_frame_serializer
  import pts_pkg::*;
#(
  parameter int NUM_SAMPLES = PTS_NUM_SAMPLES,
  parameter int SAMPLE_W    = PTS_SAMPLE_W,
  parameter int PAD_SAMPLES = PTS_PAD_SAMPLES
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic                                frame_valid,
  input  logic [NUM_SAMPLES-1:0][SAMPLE_W-1:0] data_par,
  output logic                                frame_ready,
  output logic [SAMPLE_W-1:0]                 serial_out,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last,
  output logic                                overrun,
  input  logic                                clr_overrun
);

`ifdef PTS_ZERO_PAD_EN
  localparam bit c_pad_en = 1'b1;
`else
  localparam bit c_pad_en = 1'b0;
`endif

  // Beats per frame and the derived index geometry.
  localparam int c_beats = c_pad_en ? PAD_SAMPLES : NUM_SAMPLES;
  localparam int IDX_W   = $clog2(c_beats);
  localparam int SH_W    = $clog2(NUM_SAMPLES);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(c_beats - 1);

  pts_state_t          r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [SAMPLE_W-1:0] r_shadow [NUM_SAMPLES];
  logic [SAMPLE_W-1:0] r_serial_out;
  logic                r_out_valid;
  logic                r_out_last;
  logic                r_overrun;

  logic                w_accept;
  logic                w_drop;
  logic [IDX_W-1:0]    w_next_idx;
  logic [SH_W-1:0]     w_rd_idx;
  logic [SAMPLE_W-1:0] w_next_sample;

  assign w_accept   = r_out_valid & out_ready;
  // Anything presented while not idle (including on the final accept) is lost.
  assign w_drop     = frame_valid & (r_state != IDLE);
  assign w_next_idx = r_idx + IDX_W'(1);
  assign w_rd_idx   = w_next_idx[SH_W-1:0];

`ifdef PTS_ZERO_PAD_EN
  // Beats past the captured data carry zeros.
  assign w_next_sample = ({1'b0, w_next_idx} < (IDX_W+1)'(NUM_SAMPLES)) ?
                         r_shadow[w_rd_idx] : '0;
`else
  assign w_next_sample = r_shadow[w_rd_idx];
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_serial_out <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_overrun    <= 1'b0;
      for (int i = 0; i < NUM_SAMPLES; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      // Set has priority over clear.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (frame_valid) begin
            for (int i = 0; i < NUM_SAMPLES; i++) begin
              r_shadow[i] <= data_par[i];
            end
            r_idx        <= '0;
            r_serial_out <= data_par[0];
            r_out_valid  <= 1'b1;
            r_out_last   <= 1'b0;  // frame always has at least two beats
            r_state      <= SEND;
          end
        end
        SEND: begin
          // Without an accept every output and the index hold.
          if (w_accept) begin
            if (r_idx == c_last_idx) begin
              r_idx        <= '0;
              r_serial_out <= '0;
              r_out_valid  <= 1'b0;
              r_out_last   <= 1'b0;
              r_state      <= IDLE;
            end else begin
              r_idx        <= w_next_idx;
              r_serial_out <= w_next_sample;
              r_out_last   <= (w_next_idx == c_last_idx);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign frame_ready = (r_state == IDLE);
  assign serial_out  = r_serial_out;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign overrun     = r_overrun;

endmodule : pts_frame_serializer
`default_nettype wire
